// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core and its boot/run sequencer:
// state encoding, default widths and opcode class constants.
package riscv_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_INIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_HALT  = 3'd5
    } boot_state_e;

    localparam logic [1:0] AR_TYPE = 2'd0;
    localparam logic [1:0] M_TYPE  = 2'd1;
    localparam logic [1:0] BR_TYPE = 2'd2;
    localparam logic [1:0] SH_TYPE = 2'd3;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/boot_cnt.sv
// Loadable up-counter with terminal-count flag; used for the word/register
// index and for the pipeline drain count.
module boot_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_r;

    // Counter register: load has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == tc_val);

endmodule

// File: rtl/riscv_boot_ctrl.sv
// Boot/run sequencer: streams a program into IMEM, initialises the register
// file, then runs the core for a bounded time followed by a pipeline drain.
module riscv_boot_ctrl
    import riscv_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int IMEM_DEPTH   = 32,
    parameter int RF_INIT_MODE = 1,
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_RUN      = 1024
) (
    input  logic          clk,
    input  logic          RN,
    input  logic          start,
    input  logic          stop,
    input  logic          host_valid,
    input  logic [DW-1:0] host_data,
    output logic          host_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_wdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic [2:0]    state,
    output logic [31:0]   cycle_cnt
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? DCW'(DRAIN_CYCLES - 1) : {DCW{1'b0}};
    localparam logic [AW-1:0]  LOAD_LAST  = AW'(IMEM_DEPTH - 1);
    localparam logic [AW-1:0]  INIT_LAST  = {AW{1'b1}};
    localparam logic [31:0]    RUN_LAST   = (MAX_RUN > 0) ? 32'(MAX_RUN - 1) : 32'd0;

    boot_state_e    state_r;
    boot_state_e    state_next;
    logic           start_q_r;
    logic           host_ready_r;
    logic           imem_we_r;
    logic [AW-1:0]  imem_addr_r;
    logic [DW-1:0]  imem_wdata_r;
    logic           rf_we_r;
    logic [AW-1:0]  rf_addr_r;
    logic [DW-1:0]  rf_wdata_r;
    logic           core_rst_r;
    logic           busy_r;
    logic           done_r;
    logic [31:0]    cycle_cnt_r;

    logic           accept_s;
    logic           init_wr_s;
    logic           run_limit_s;
    logic           state_chg_s;
    logic [AW-1:0]  idx_cnt_s;
    logic [AW-1:0]  idx_last_s;
    logic           idx_tc_s;
    logic [DCW-1:0] drain_cnt_unused_s;
    logic           drain_tc_s;

    function automatic logic [DW-1:0] rf_init_val(input logic [AW-1:0] k);
        if ((k == {AW{1'b0}}) || (RF_INIT_MODE == 0)) begin
            return {DW{1'b0}};
        end else begin
            return DW'(k);
        end
    endfunction

    assign accept_s    = (state_r == ST_LOAD) && host_valid && host_ready_r && !stop;
    assign init_wr_s   = (state_r == ST_INIT) && !stop;
    assign run_limit_s = (MAX_RUN != 0) && (cycle_cnt_r == RUN_LAST);
    assign state_chg_s = (state_next != state_r);

    // The shared index counter terminates at the program length while loading
    // and at the last register while initialising.
    always_comb begin
        idx_last_s = INIT_LAST;
        if (state_r == ST_LOAD) begin
            idx_last_s = LOAD_LAST;
        end else begin
            idx_last_s = INIT_LAST;
        end
    end

    boot_cnt #(.W(AW)) u_idx_cnt (
        .clk      (clk),
        .rst_n    (RN),
        .load     (state_chg_s),
        .load_val ({AW{1'b0}}),
        .en       (accept_s || init_wr_s),
        .tc_val   (idx_last_s),
        .cnt      (idx_cnt_s),
        .tc       (idx_tc_s)
    );

    boot_cnt #(.W(DCW)) u_drain_cnt (
        .clk      (clk),
        .rst_n    (RN),
        .load     (state_chg_s),
        .load_val ({DCW{1'b0}}),
        .en       (state_r == ST_DRAIN),
        .tc_val   (DRAIN_LAST),
        .cnt      (drain_cnt_unused_s),
        .tc       (drain_tc_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic; start acts through a registered, state-qualified copy.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_q_r) state_next = ST_LOAD;
                else           state_next = state_r;
            end
            ST_LOAD: begin
                if (stop)                      state_next = ST_IDLE;
                else if (accept_s && idx_tc_s) state_next = ST_INIT;
                else                           state_next = state_r;
            end
            ST_INIT: begin
                if (stop)          state_next = ST_IDLE;
                else if (idx_tc_s) state_next = ST_RUN;
                else               state_next = state_r;
            end
            ST_RUN: begin
                if (stop || run_limit_s) begin
                    if (DRAIN_CYCLES == 0) state_next = ST_HALT;
                    else                   state_next = ST_DRAIN;
                end else begin
                    state_next = state_r;
                end
            end
            ST_DRAIN: begin
                if (drain_tc_s) state_next = ST_HALT;
                else            state_next = state_r;
            end
            ST_HALT: begin
                if (start_q_r) state_next = ST_LOAD;
                else           state_next = state_r;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            start_q_r    <= 1'b0;
            host_ready_r <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {AW{1'b0}};
            imem_wdata_r <= {DW{1'b0}};
            rf_we_r      <= 1'b0;
            rf_addr_r    <= {AW{1'b0}};
            rf_wdata_r   <= {DW{1'b0}};
            core_rst_r   <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            start_q_r    <= start && ((state_r == ST_IDLE) || (state_r == ST_HALT));
            host_ready_r <= (state_next == ST_LOAD);
            busy_r       <= (state_next != ST_IDLE) && (state_next != ST_HALT);
            done_r       <= (state_next == ST_HALT);
            core_rst_r   <= (state_next != ST_RUN) && (state_next != ST_DRAIN);
            imem_we_r    <= accept_s;
            rf_we_r      <= init_wr_s;
            if (accept_s) begin
                imem_addr_r  <= idx_cnt_s;
                imem_wdata_r <= host_data;
            end
            if (init_wr_s) begin
                rf_addr_r  <= idx_cnt_s;
                rf_wdata_r <= rf_init_val(idx_cnt_s);
            end
        end
    end

    // Run-cycle counter: cleared on RUN entry, saturating through RUN and DRAIN.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            cycle_cnt_r <= 32'd0;
        end else if ((state_r == ST_INIT) && (state_next == ST_RUN)) begin
            cycle_cnt_r <= 32'd0;
        end else if ((state_r == ST_RUN) || (state_r == ST_DRAIN)) begin
            cycle_cnt_r <= sat_inc32(cycle_cnt_r);
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign host_ready = host_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign rf_we      = rf_we_r;
    assign rf_addr    = rf_addr_r;
    assign rf_wdata   = rf_wdata_r;
    assign core_rst   = core_rst_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign state      = state_r;
    assign cycle_cnt  = cycle_cnt_r;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Scoreboard bench for riscv_boot_ctrl: expected IMEM/REG writes are queued as
// stimulus is issued and popped by a monitor whenever a write strobe appears.
module tb_riscv_boot_ctrl;

    localparam int AW           = 5;
    localparam int DW           = 32;
    localparam int IMEM_DEPTH   = 32;
    localparam int RF_INIT_MODE = 1;
    localparam int DRAIN_CYCLES = 4;
    localparam int MAX_RUN      = 10;
    localparam int NREGS        = 1 << AW;

    logic          clk = 1'b0;
    logic          RN;
    logic          start;
    logic          stop;
    logic          host_valid;
    logic [DW-1:0] host_data;
    logic          host_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic [2:0]    state;
    logic [31:0]   cycle_cnt;

    riscv_boot_ctrl #(
        .AW(AW), .DW(DW), .IMEM_DEPTH(IMEM_DEPTH), .RF_INIT_MODE(RF_INIT_MODE),
        .DRAIN_CYCLES(DRAIN_CYCLES), .MAX_RUN(MAX_RUN)
    ) dut (
        .clk(clk), .RN(RN), .start(start), .stop(stop),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .core_rst(core_rst), .busy(busy), .done(done), .state(state),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_imem[$];
    wr_t exp_rf[$];
    wr_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Reference: the run lasts until stop or the limit, whichever is first.
    function automatic int exp_run_len(input int stop_at);
        if (stop_at != 0 && stop_at < MAX_RUN) return stop_at;
        return MAX_RUN;
    endfunction

    // Monitor: every write strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (RN === 1'b1) begin
            if (imem_we || rf_we) chk("we_exclusive", {31'd0, imem_we & rf_we}, 32'd0);
            if (imem_we) begin
                if (exp_imem.size() == 0) begin
                    fail_now("imem_unexpected", $sformatf("addr %0d data 0x%0h, none expected", imem_addr, imem_wdata));
                end else begin
                    mon_e = exp_imem.pop_front();
                    chk("imem_addr", 32'(imem_addr), 32'(mon_e.addr));
                    chk("imem_data", imem_wdata, mon_e.data);
                end
            end
            if (rf_we) begin
                if (exp_rf.size() == 0) begin
                    fail_now("rf_unexpected", $sformatf("addr %0d data 0x%0h, none expected", rf_addr, rf_wdata));
                end else begin
                    mon_e = exp_rf.pop_front();
                    chk("rf_addr", 32'(rf_addr), 32'(mon_e.addr));
                    chk("rf_data", rf_wdata, mon_e.data);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input bit toggle, input int abort_after, output int start_cyc, output bit complete);
        int cnt;
        int guard;
        bit seen_ready;
        bit aborting;
        wr_t w;
        cnt = 0; guard = 0; seen_ready = 1'b0; aborting = 1'b0; complete = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cnt < IMEM_DEPTH && guard < 400 && !aborting) begin
            guard++;
            aborting   = (cnt == abort_after);
            host_valid = aborting ? 1'b1 : (toggle ? guard[0] : 1'b1);
            stop       = aborting;
            host_data  = toggle ? $urandom() : (32'h0220_8300 + 32'(cnt));
            @(negedge clk);
            if (host_ready === 1'b1 && !seen_ready) begin
                seen_ready = 1'b1;
                chk("done_clear_on_load", {31'd0, done}, 32'd0);
            end
            if (seen_ready) chk("host_ready_in_load", {31'd0, host_ready}, 32'd1);
            if (host_ready && host_valid && !stop) begin
                w.addr = AW'(cnt);
                w.data = host_data;
                exp_imem.push_back(w);
                cnt++;
            end
            @(posedge clk); #1;
        end
        host_valid = 1'b0;
        stop       = 1'b0;
        if (aborting) begin
            chk("abort_to_idle", 32'(state), 32'd0);
            chk("abort_ready_low", {31'd0, host_ready}, 32'd0);
        end else if (cnt == IMEM_DEPTH) begin
            complete = 1'b1;
            chk("load_to_init", 32'(state), 32'd2);
            chk("ready_low_in_init", {31'd0, host_ready}, 32'd0);
            for (int k = 0; k < NREGS; k++) begin
                w.addr = AW'(k);
                w.data = (k == 0 || RF_INIT_MODE == 0) ? 32'd0 : 32'(k);
                exp_rf.push_back(w);
            end
        end else begin
            fail_now("load_timeout", $sformatf("only %0d of %0d words accepted", cnt, IMEM_DEPTH));
        end
    endtask

    task automatic wait_run_start(input int start_cyc, input bit check_timing);
        int g;
        g = 0;
        while (core_rst !== 1'b0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (core_rst !== 1'b0) begin
            fail_now("run_start_timeout", "core_rst never released");
        end else if (check_timing) begin
            chk("core_rst_fall_cycle", 32'(cyc - start_cyc), 32'(2 + IMEM_DEPTH + NREGS));
        end
    endtask

    // Called at the first negedge with core_rst low; start is pulsed in RUN
    // and in the last DRAIN cycle, where it must be ignored.
    task automatic run_phase(input int stop_at);
        int r;
        int l;
        int n;
        r = exp_run_len(stop_at);
        l = r + DRAIN_CYCLES;
        n = 0;
        while (core_rst === 1'b0 && n < 2000) begin
            n++;
            if (n == 1) chk("cnt_cleared_on_entry", cycle_cnt, 32'd0);
            if (n == r) begin
                chk("state_last_run", 32'(state), 32'd3);
                chk("cnt_last_run", cycle_cnt, 32'(r - 1));
            end
            if (n == r + 1) begin
                chk("state_drain_entry", 32'(state), 32'd4);
                chk("cnt_drain_entry", cycle_cnt, 32'(r));
            end
            chk("busy_while_running", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            stop  = (n + 1 == stop_at);
            start = (n + 1 == 3) || (n + 1 == l);
            @(negedge clk);
        end
        stop  = 1'b0;
        start = 1'b0;
        chk("core_low_cycles", 32'(n), 32'(l));
        chk("done_in_halt", {31'd0, done}, 32'd1);
        chk("state_halt", 32'(state), 32'd5);
        chk("busy_in_halt", {31'd0, busy}, 32'd0);
        chk("cycle_cnt_final", cycle_cnt, 32'(l));
        wait_cycles(3);
        chk("halt_holds", 32'(state), 32'd5);
        chk("cycle_cnt_held", cycle_cnt, 32'(l));
        chk("core_rst_in_halt", {31'd0, core_rst}, 32'd1);
    endtask

    initial begin
        int  sc;
        bit  ok;
        RN = 1'b1; start = 1'b0; stop = 1'b0; host_valid = 1'b0; host_data = '0;
        #1 RN = 1'b0;
        wait_cycles(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, host_ready}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        #2 RN = 1'b1;
        wait_cycles(3);
        chk("idle_without_start", 32'(state), 32'd0);

        // Full program, limit-terminated run.
        do_load(1'b0, -1, sc, ok);
        wait_run_start(sc, 1'b1);
        run_phase(0);

        // Toggling valid with random words; stop in the 5th RUN cycle.
        do_load(1'b1, -1, sc, ok);
        wait_run_start(sc, 1'b0);
        run_phase(5);

        // Stop coincides with the run limit.
        do_load(1'b0, -1, sc, ok);
        wait_run_start(sc, 1'b1);
        run_phase(MAX_RUN);

        // Abort after 7 words, then a fresh load restarting at address 0.
        do_load(1'b0, 7, sc, ok);
        wait_cycles(4);
        chk("idle_after_abort", 32'(state), 32'd0);
        do_load(1'b1, -1, sc, ok);
        wait_run_start(sc, 1'b0);
        run_phase(int'($urandom_range(2, 12)));

        // Asynchronous reset in the middle of register initialisation.
        do_load(1'b0, -1, sc, ok);
        wait_cycles(5);
        chk("state_init_before_rst", 32'(state), 32'd2);
        #2 RN = 1'b0;
        #1;
        chk("midrst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("midrst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        exp_rf.delete();
        wait_cycles(2);
        #2 RN = 1'b1;
        wait_cycles(6);
        chk("post_rst_idle", 32'(state), 32'd0);
        chk("post_rst_core_rst", {31'd0, core_rst}, 32'd1);
        do_load(1'b1, -1, sc, ok);
        wait_run_start(sc, 1'b0);
        run_phase(int'($urandom_range(2, 12)));

        wait_cycles(2);
        chk("imem_queue_drained", 32'(exp_imem.size()), 32'd0);
        chk("rf_queue_drained", 32'(exp_rf.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the sequence completed");
        $fatal(1, "watchdog expired");
    end

endmodule
